dff_mem_ctrl: RTL and testbench

Parametrised flip-flop memory with a valid/ready command port, single-beat and auto-incrementing burst reads, and a hardware clear sweep. Successor to the fixed 8-bit DFF memory tile: width and depth are generic, and reads return through a backpressured response port. Intended to sit behind the Tiny Tapeout pin-mapping wrapper, which serialises `ui_in`/`uio_in` into commands.

---
 rtl/dff_mem_pkg.sv | 19 +
 rtl/dff_mem_array.sv | 42 ++++
 rtl/dff_mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dff_mem_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_mem_pkg.sv
// Shared types for the parametrised flip-flop memory controller.
//   cmd_op_e : command opcodes carried on cmd_op
//   state_e  : controller FSM states
package dff_mem_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_BURST = 2'b10,
      OP_CLEAR = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BURST = 2'b01,
      ST_CLEAR = 2'b10
   } state_e;

endpackage

// File: rtl/dff_mem_array.sv
// DATA_W x DEPTH flip-flop storage with no reset.
//   clk     : write clock, rising edge
//   wr_en   : write strobe; writes to addresses >= DEPTH are dropped
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : combinational read address
//   rd_data : read data, 0 for addresses >= DEPTH
module dff_mem_array #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   // Addresses are compared one bit wider so DEPTH itself is representable
   // when DEPTH is a power of two.
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   // Synchronous write port; out-of-range addresses never touch storage.
   always_ff @(posedge clk) begin
      if (wr_en && ({1'b0, wr_addr} < DEPTH_X)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Combinational read port returning zero for holes above DEPTH-1.
   always_comb begin
      rd_data = '0;
      if ({1'b0, rd_addr} < DEPTH_X) begin
         rd_data = mem[rd_addr];
      end
   end

endmodule

// File: rtl/dff_mem_ctrl.sv
// Command-driven controller around dff_mem_array: single reads and writes,
// auto-incrementing bursts returned through a backpressured response port,
// and a one-word-per-cycle clear sweep.
//   clk, rst                 : clock and synchronous active-high reset
//   cmd_valid/cmd_ready      : command handshake
//   cmd_op/addr/len/wdata    : opcode, start address, burst beats-1, write data
//   rd_valid/rd_ready        : response handshake
//   rd_data/rd_last          : response word and final-beat flag
//   busy                     : high while bursting or clearing
module dff_mem_ctrl #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   input  logic              rd_ready,
   output logic              busy
);

   import dff_mem_pkg::*;

   localparam logic [ADDR_W:0] LAST_X = (ADDR_W+1)'(DEPTH - 1);

   state_e            state, state_n;
   cmd_op_e           op;
   logic [ADDR_W-1:0] ptr, ptr_n;
   logic [ADDR_W-1:0] remaining, remaining_n;
   logic              rd_valid_n, rd_last_n;
   logic [DATA_W-1:0] rd_data_n;
   logic              accept, beat_take;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr, mem_raddr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;

   // Wrap at DEPTH-1 by explicit compare; anything at or beyond the last
   // word (including out-of-range starts) goes back to zero.
   function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
      if ({1'b0, a} >= LAST_X) begin
         return '0;
      end
      return a + 1'b1;
   endfunction

   assign op        = cmd_op_e'(cmd_op);
   assign cmd_ready = (state == ST_IDLE) && (!rd_valid || rd_ready) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign beat_take = rd_valid && rd_ready;
   assign busy      = (state != ST_IDLE);

   // Bursts read from the running pointer; everything else reads the
   // command address so a READ/BURST head beat is loaded at its handshake.
   assign mem_raddr = (state == ST_BURST) ? ptr : cmd_addr;

   // The clear sweep owns the write port; the reset edge writes nothing so
   // an aborted sweep leaves the not-yet-cleared words intact.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = cmd_addr;
      mem_wdata = cmd_wdata;
      if (!rst) begin
         if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr;
            mem_wdata = '0;
         end else if (accept && op == OP_WRITE) begin
            mem_we = 1'b1;
         end
      end
   end

   dff_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (mem_waddr),
      .wr_data (mem_wdata),
      .rd_addr (mem_raddr),
      .rd_data (mem_rdata)
   );

   // State register plus pointer, beat counter and response register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         remaining <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         rd_last   <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         remaining <= remaining_n;
         rd_valid  <= rd_valid_n;
         rd_data   <= rd_data_n;
         rd_last   <= rd_last_n;
      end
   end

   // Next-state and datapath decisions. In BURST, 'remaining' counts the
   // beats still to be loaded after the one currently presented, so zero
   // means the presented beat is the last.
   always_comb begin
      state_n     = state;
      ptr_n       = ptr;
      remaining_n = remaining;
      rd_valid_n  = rd_valid;
      rd_data_n   = rd_data;
      rd_last_n   = rd_last;

      case (state)
         ST_IDLE: begin
            if (beat_take) begin
               rd_valid_n = 1'b0;
            end
            if (accept) begin
               case (op)
                  OP_READ: begin
                     rd_valid_n = 1'b1;
                     rd_data_n  = mem_rdata;
                     rd_last_n  = 1'b1;
                  end
                  OP_BURST: begin
                     rd_valid_n  = 1'b1;
                     rd_data_n   = mem_rdata;
                     remaining_n = cmd_len;
                     ptr_n       = wrap_inc(cmd_addr);
                     if (cmd_len == '0) begin
                        rd_last_n = 1'b1;
                     end else begin
                        rd_last_n = 1'b0;
                        state_n   = ST_BURST;
                     end
                  end
                  OP_CLEAR: begin
                     ptr_n   = '0;
                     state_n = ST_CLEAR;
                  end
                  default: begin
                  end
               endcase
            end
         end

         ST_BURST: begin
            if (beat_take) begin
               if (remaining == '0) begin
                  rd_valid_n = 1'b0;
                  state_n    = ST_IDLE;
               end else begin
                  rd_data_n   = mem_rdata;
                  ptr_n       = wrap_inc(ptr);
                  remaining_n = remaining - 1'b1;
                  rd_last_n   = (remaining == ADDR_W'(1));
               end
            end
         end

         ST_CLEAR: begin
            ptr_n = wrap_inc(ptr);
            if ({1'b0, ptr} >= LAST_X) begin
               state_n = ST_IDLE;
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dff_mem_ctrl.sv
// Self-checking bench for dff_mem_ctrl. Two instances (DEPTH 16 and 12)
// share the clock; one is exercised at a time against a transaction-level
// model that keeps memory as an array and responses as a queue of beats.
module tb_dff_mem_ctrl;

   import dff_mem_pkg::*;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct {
      int         dut;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } rw_vec_t;

   logic              clk = 1'b0;
   logic              rst       [2];
   logic              cmd_valid [2];
   logic              cmd_ready [2];
   logic [1:0]        cmd_op    [2];
   logic [ADDR_W-1:0] cmd_addr  [2];
   logic [ADDR_W-1:0] cmd_len   [2];
   logic [DATA_W-1:0] cmd_wdata [2];
   logic              rd_valid  [2];
   logic [DATA_W-1:0] rd_data   [2];
   logic              rd_last   [2];
   logic              rd_ready  [2];
   logic              busy      [2];

   int errors = 0;
   int checks = 0;
   int cur    = 0;

   // Reference model state
   int         depth = 16;
   logic [7:0] mmem [16];
   beat_t      pend_q [$];
   bit         burst_active = 1'b0;
   int         clear_left = 0;

   always #5 clk = ~clk;

   dff_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(16), .ADDR_W(ADDR_W)) dut16 (
      .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_op(cmd_op[0]), .cmd_addr(cmd_addr[0]), .cmd_len(cmd_len[0]),
      .cmd_wdata(cmd_wdata[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
      .rd_last(rd_last[0]), .rd_ready(rd_ready[0]), .busy(busy[0])
   );

   dff_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(12), .ADDR_W(ADDR_W)) dut12 (
      .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_op(cmd_op[1]), .cmd_addr(cmd_addr[1]), .cmd_len(cmd_len[1]),
      .cmd_wdata(cmd_wdata[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
      .rd_last(rd_last[1]), .rd_ready(rd_ready[1]), .busy(busy[1])
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] model_read(input int a);
      return (a < depth) ? mmem[a] : 8'h00;
   endfunction

   task automatic checkOutput(input logic exp_ready, input logic exp_valid, input logic exp_busy);
      cmp("cmd_ready", cmd_ready[cur], exp_ready);
      cmp("rd_valid", rd_valid[cur], exp_valid);
      cmp("busy", busy[cur], exp_busy);
      if (exp_valid) begin
         cmp("rd_data", rd_data[cur], pend_q[0].data);
         cmp("rd_last", rd_last[cur], pend_q[0].last);
      end
   endtask

   // One clock cycle: drive at the falling edge, check shortly after, then
   // advance the model by what the coming rising edge will do.
   task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [3:0] addr,
                                input logic [3:0] len, input logic [7:0] wd,
                                input logic rdy, input logic r);
      logic  exp_ready, exp_valid, acc, take;
      int    a, l;
      beat_t b;
      @(negedge clk);
      cmd_valid[cur] = v;
      cmd_op[cur]    = op;
      cmd_addr[cur]  = addr;
      cmd_len[cur]   = len;
      cmd_wdata[cur] = wd;
      rd_ready[cur]  = rdy;
      rst[cur]       = r;
      #1;
      exp_valid = (pend_q.size() > 0);
      exp_ready = !r && (clear_left == 0) && !burst_active && (!exp_valid || rdy);
      checkOutput(exp_ready, exp_valid, (clear_left > 0) || burst_active);
      acc  = v && exp_ready;
      take = exp_valid && rdy;
      if (r) begin
         pend_q.delete();
         burst_active = 1'b0;
         clear_left   = 0;
      end else begin
         if (clear_left > 0) begin
            mmem[depth - clear_left] = 8'h00;
            clear_left--;
         end
         if (take) begin
            if (pend_q[0].last) burst_active = 1'b0;
            void'(pend_q.pop_front());
         end
         if (acc) begin
            case (op)
               OP_WRITE: if (int'(addr) < depth) mmem[addr] = wd;
               OP_READ: begin
                  b.data = model_read(int'(addr));
                  b.last = 1'b1;
                  pend_q.push_back(b);
               end
               OP_BURST: begin
                  a = int'(addr);
                  l = int'(len);
                  for (int i = 0; i <= l; i++) begin
                     b.data = model_read(a);
                     b.last = (i == l);
                     pend_q.push_back(b);
                     a = (a + 1 >= depth) ? 0 : a + 1;
                  end
                  burst_active = (l != 0);
               end
               default: clear_left = depth;
            endcase
         end
      end
   endtask

   task automatic idle_cycle(input logic rdy);
      applyStimulus(1'b0, OP_READ, 4'd0, 4'd0, 8'h00, rdy, 1'b0);
   endtask

   task automatic reset_dut(input int d);
      for (int k = 0; k < 2; k++) begin
         cmd_valid[k] = 1'b0;
         rd_ready[k]  = 1'b1;
         rst[k]       = 1'b0;
      end
      cur   = d;
      depth = (d == 0) ? 16 : 12;
      @(negedge clk);
      rst[cur] = 1'b1;
      #1;
      cmp("cmd_ready_in_reset", cmd_ready[cur], 1'b0);
      pend_q.delete();
      burst_active = 1'b0;
      clear_left   = 0;
      applyStimulus(1'b0, OP_READ, 4'd0, 4'd0, 8'h00, 1'b1, 1'b1);
      idle_cycle(1'b1);
      cmp("reset_rd_data", rd_data[cur], 8'h00);
      cmp("reset_rd_last", rd_last[cur], 1'b0);
   endtask

   task automatic fill(input logic [7:0] base);
      for (int i = 0; i < depth; i++) begin
         applyStimulus(1'b1, OP_WRITE, 4'(i), 4'd0, base + 8'(i), 1'b1, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rw_vec_t    rw_tab [6];
      logic [7:0] burst_exp [4];
      logic [7:0] b12_exp [3];
      bit         stall_pat [4];
      int         beats, cnt;
      logic       rdy, v, r;
      logic [1:0] op;

      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b0; cmd_valid[k] = 1'b0; cmd_op[k] = 2'b00; cmd_addr[k] = '0;
         cmd_len[k] = '0; cmd_wdata[k] = '0; rd_ready[k] = 1'b1;
      end

      rw_tab[0] = '{0, 4'd3,  8'hA5, 8'hA5};
      rw_tab[1] = '{0, 4'd15, 8'h5A, 8'h5A};
      rw_tab[2] = '{0, 4'd0,  8'hC3, 8'hC3};
      rw_tab[3] = '{1, 4'd13, 8'h77, 8'h00};
      rw_tab[4] = '{1, 4'd11, 8'h3C, 8'h3C};
      rw_tab[5] = '{1, 4'd14, 8'hE1, 8'h00};
      burst_exp = '{8'h1E, 8'h1F, 8'h10, 8'h11};
      b12_exp   = '{8'h4A, 8'h4B, 8'h40};
      stall_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

      // Write-then-read vectors, including dropped out-of-range writes.
      for (int d = 0; d < 2; d++) begin
         reset_dut(d);
         for (int i = 0; i < 6; i++) begin
            if (rw_tab[i].dut == d) begin
               applyStimulus(1'b1, OP_WRITE, rw_tab[i].addr, 4'd0, rw_tab[i].wdata, 1'b1, 1'b0);
               applyStimulus(1'b1, OP_READ, rw_tab[i].addr, 4'd0, 8'h00, 1'b0, 1'b0);
               idle_cycle(1'b1);
               cmp("vec_rd_valid", rd_valid[cur], 1'b1);
               cmp("vec_rd_data", rd_data[cur], rw_tab[i].exp);
               cmp("vec_rd_last", rd_last[cur], 1'b1);
            end
         end
      end

      // Wrapping burst at full throughput, with a competing WRITE offered.
      reset_dut(0);
      fill(8'h10);
      applyStimulus(1'b1, OP_BURST, 4'd14, 4'd3, 8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, OP_WRITE, 4'd0, 4'd0, 8'hFF, 1'b1, 1'b0);
         cmp("burst_valid", rd_valid[cur], 1'b1);
         cmp("burst_data", rd_data[cur], burst_exp[k]);
         cmp("burst_last", rd_last[cur], (k == 3));
      end
      idle_cycle(1'b1);

      // Same burst under backpressure.
      applyStimulus(1'b1, OP_BURST, 4'd14, 4'd3, 8'h00, 1'b1, 1'b0);
      beats = 0;
      for (int c = 0; c < 30 && beats < 4; c++) begin
         rdy = stall_pat[c % 4];
         applyStimulus(1'b1, OP_WRITE, 4'd0, 4'd0, 8'hFF, rdy, 1'b0);
         cmp("stall_cmd_ready", cmd_ready[cur], 1'b0);
         if (rd_valid[cur] && rdy) begin
            cmp("stall_data", rd_data[cur], burst_exp[beats]);
            cmp("stall_last", rd_last[cur], (beats == 3));
            beats++;
         end
      end
      cmp("stall_beats", beats, 4);
      idle_cycle(1'b1);

      // Clear sweep length, then read everything back as zero.
      applyStimulus(1'b1, OP_CLEAR, 4'd7, 4'd0, 8'h00, 1'b1, 1'b0);
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         idle_cycle(1'b1);
         if (busy[cur]) cnt++;
      end
      cmp("clear_busy_cycles", cnt, 16);
      applyStimulus(1'b1, OP_BURST, 4'd0, 4'd15, 8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 16; k++) begin
         idle_cycle(1'b1);
         cmp("cleared_word", rd_data[cur], 8'h00);
      end
      idle_cycle(1'b1);

      // Non-power-of-two depth: dropped write, zero read, wrap at 11.
      reset_dut(1);
      fill(8'h40);
      applyStimulus(1'b1, OP_WRITE, 4'd13, 4'd0, 8'h99, 1'b1, 1'b0);
      applyStimulus(1'b1, OP_READ, 4'd13, 4'd0, 8'h00, 1'b1, 1'b0);
      idle_cycle(1'b1);
      cmp("oor_read", rd_data[cur], 8'h00);
      applyStimulus(1'b1, OP_BURST, 4'd10, 4'd2, 8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         idle_cycle(1'b1);
         cmp("b12_data", rd_data[cur], b12_exp[k]);
      end
      applyStimulus(1'b1, OP_BURST, 4'd13, 4'd1, 8'h00, 1'b1, 1'b0);
      idle_cycle(1'b1);
      cmp("oor_burst_beat0", rd_data[cur], 8'h00);
      idle_cycle(1'b1);
      cmp("oor_burst_beat1", rd_data[cur], 8'h40);
      idle_cycle(1'b1);

      // Reset during a burst, then during a clear sweep.
      reset_dut(0);
      fill(8'h10);
      applyStimulus(1'b1, OP_BURST, 4'd0, 4'd10, 8'h00, 1'b1, 1'b0);
      idle_cycle(1'b1);
      idle_cycle(1'b1);
      applyStimulus(1'b0, OP_READ, 4'd0, 4'd0, 8'h00, 1'b1, 1'b1);
      idle_cycle(1'b1);
      cmp("rst_burst_data", rd_data[cur], 8'h00);
      cmp("rst_burst_last", rd_last[cur], 1'b0);
      applyStimulus(1'b1, OP_CLEAR, 4'd0, 4'd0, 8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) idle_cycle(1'b1);
      applyStimulus(1'b0, OP_READ, 4'd0, 4'd0, 8'h00, 1'b1, 1'b1);
      applyStimulus(1'b1, OP_READ, 4'd3, 4'd0, 8'h00, 1'b1, 1'b0);
      cmp("rst_clear_busy", busy[cur], 1'b0);
      applyStimulus(1'b1, OP_READ, 4'd7, 4'd0, 8'h00, 1'b1, 1'b0);
      cmp("cleared_addr3", rd_data[cur], 8'h00);
      idle_cycle(1'b1);
      cmp("kept_addr7", rd_data[cur], 8'h17);
      applyStimulus(1'b1, OP_BURST, 4'd0, 4'd15, 8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 17; k++) idle_cycle(1'b1);

      // Randomized traffic on both depths against the model.
      for (int d = 0; d < 2; d++) begin
         reset_dut(d);
         fill(8'($urandom_range(0, 255)));
         for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 63) == 0);
            v   = $urandom_range(0, 1) == 1;
            op  = ($urandom_range(0, 15) == 0) ? OP_CLEAR : 2'($urandom_range(0, 2));
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(v, op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          8'($urandom_range(0, 255)), rdy, r);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
